// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: opcodes, instruction-word
// field positions and the fetch FSM state encoding.
package proc_pkg;

  localparam logic [3:0] OPC_NOP = 4'b0000;
  localparam logic [3:0] OPC_LD  = 4'b0001;
  localparam logic [3:0] OPC_STR = 4'b0010;
  localparam logic [3:0] OPC_BRA = 4'b0011;
  localparam logic [3:0] OPC_XOR = 4'b0100;
  localparam logic [3:0] OPC_ADD = 4'b0101;
  localparam logic [3:0] OPC_ROT = 4'b0110;
  localparam logic [3:0] OPC_SHF = 4'b0111;
  localparam logic [3:0] OPC_HLT = 4'b1000;
  localparam logic [3:0] OPC_CMP = 4'b1001;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int IMM_BIT = 27;
  localparam int SRC_MSB = 23;
  localparam int SRC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch/issue stage: reads instruction words from a synchronous-read program
// memory, decodes them into proc fields and offers them under valid/ready.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int             BUSW     = 32,
  parameter int             OPW      = 4,
  parameter int             FLDW     = 12,
  parameter int             PCW      = 8,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter logic [OPW-1:0] NOP      = OPW'(OPC_NOP),
  parameter logic [OPW-1:0] HLT      = OPW'(OPC_HLT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            mem_rd,
  output logic [PCW-1:0]  mem_addr,
  input  logic [31:0]     mem_rdata,
  input  logic            br_taken,
  input  logic [PCW-1:0]  br_target,
  output logic [OPW-1:0]  Opcode,
  output logic            srcIsImm,
  output logic [BUSW-1:0] SrcOp,
  output logic [BUSW-1:0] DstOp,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic            halted,
  output logic [PCW-1:0]  pc
);

  fetch_state_e    state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic            imm_q, imm_d;
  logic [BUSW-1:0] src_q, src_d;
  logic [BUSW-1:0] dst_q, dst_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;

  // Reserved word bits [26:24] carry no meaning for this stage.
  logic unused_rsvd;
  assign unused_rsvd = ^{mem_rdata[IMM_BIT-1:SRC_MSB+1], mem_rdata[DST_MSB]};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    src_d    = src_q;
    dst_d    = dst_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    case (state_q)
      ST_IDLE: begin
        if (br_taken) begin
          pc_d = br_target;
        end else if (start) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (br_taken) begin
          pc_d    = br_target;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (br_taken) begin
          // The read for the old PC is still returning; drop it and refetch.
          pc_d    = br_target;
          state_d = ST_FETCH;
        end else begin
          opcode_d = mem_rdata[OP_LSB +: OPW];
          imm_d    = mem_rdata[IMM_BIT];
          src_d    = BUSW'(mem_rdata[SRC_LSB +: FLDW]);
          dst_d    = BUSW'(mem_rdata[DST_LSB +: FLDW]);
          valid_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (issue_ready || br_taken) begin
          opcode_d = NOP;
          imm_d    = 1'b0;
          src_d    = '0;
          dst_d    = '0;
          valid_d  = 1'b0;
          state_d  = ST_FETCH;
          if (issue_ready && opcode_q == HLT) begin
            // A halt that issues wins over any simultaneous redirect.
            pc_d     = pc_q + PCW'(1);
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= NOP;
      imm_q    <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign mem_rd      = (state_q == ST_FETCH);
  assign mem_addr    = pc_q;
  assign Opcode      = opcode_q;
  assign srcIsImm    = imm_q;
  assign SrcOp       = src_q;
  assign DstOp       = dst_q;
  assign issue_valid = valid_q;
  assign halted      = halted_q;
  assign pc          = pc_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and issue stage directly upstream of `proc`. It holds the program counter and reads 32-bit instruction words from a synchronous-read program memory. It splits each word into the `Opcode`/`DstOp`/`SrcOp`/`srcIsImm` fields that `proc` consumes and presents them under a valid/ready handshake. It also handles branch redirects from the CPU and stops permanently after issuing HLT.

## Interface
- `BUSW`, 32, width of `DstOp`/`SrcOp` outputs (≥ FLDW)
- `OPW`, 4, opcode width
- `FLDW`, 12, operand field width in the instruction word
- `PCW`, 8, program counter / memory address width
- `RESET_PC`, 0, PC value after reset
- `NOP`, 4'b0000, opcode presented while no instruction is held
- `HLT`, 4'b1000, halt opcode
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins fetching from current PC when IDLE
- `mem_rd`  out  1  read strobe to program memory
- `mem_addr`  out  PCW  read address
- `mem_rdata`  in  32  instruction word, valid the cycle after `mem_rd`
- `br_taken`  in  1  redirect request from CPU
- `br_target`  in  PCW  redirect address
- `Opcode`  out  OPW  word[31:28]
- `srcIsImm`  out  1  word[27]
- `SrcOp`  out  BUSW  word[23:12], zero-extended
- `DstOp`  out  BUSW  word[11:0], zero-extended; word[26:24] reserved and ignored
- `issue_valid`  out  1  fields hold a valid instruction
- `issue_ready`  in  1  `proc` accepts the instruction
- `halted`  out  1  HLT has been issued
- `pc`  out  PCW  current program counter (debug)

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE, HALTED. Reset state is IDLE.
- IDLE: `start`=1 → FETCH.
- FETCH: `mem_rd`=1 and `mem_addr`=`pc` (combinational from state/PC). Next state is WAIT.
- WAIT: `mem_rdata` is registered into the output fields and `issue_valid` is set. Next state is ISSUE.
- ISSUE: `issue_valid`=1 and the fields are held stable until `issue_ready`=1. On handshake:
  - `pc` ← `pc`+1, wrapping modulo 2^PCW (2^PCW−1 → 0).
  - `issue_valid` ← 0 and the fields return to NOP/0.
  - If `Opcode`==HLT the next state is HALTED; otherwise FETCH.
- HALTED: `halted`=1 and all inputs except `rst_n` are ignored. The block leaves HALTED only via reset.
- `br_taken` behaviour by state:
  - IDLE: `pc` ← `br_target`; remain in IDLE.
  - FETCH/WAIT: `pc` ← `br_target`; any in-flight read data is discarded; next state FETCH.
  - ISSUE without handshake: the held instruction is dropped (`issue_valid` 0 next cycle); `pc` ← `br_target`; next state FETCH.
  - ISSUE with handshake in the same cycle: the instruction counts as issued and the redirect wins for the PC (`pc` ← `br_target`, not `pc`+1). A HLT issued in that cycle still goes to HALTED, and the redirect is ignored.
- `start` outside IDLE is ignored.
- Reset values: `pc`=RESET_PC; `Opcode`=NOP; `SrcOp`=`DstOp`=0; `srcIsImm`=0; `issue_valid`=0; `mem_rd`=0; `mem_addr`=RESET_PC; `halted`=0.

## Timing
- `start` sampled at edge 0 → `mem_rd` high in cycle 1 → `issue_valid` high from cycle 3.
- Peak throughput is one instruction per 3 cycles with `issue_ready` tied high.
- `issue_valid` does not depend combinationally on `issue_ready`. All outputs except `mem_rd`/`mem_addr` are registered.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). An in-flight memory read is discarded. After `rst_n` rises, the block waits in IDLE for `start`.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants (NOP, LD, STR, BRA, XOR, ADD, ROT, SHF, HLT, CMP);
  - instruction-word field positions (OP_MSB=31, OP_LSB=28, IMM_BIT=27, SRC_MSB=23, SRC_LSB=12, DST_MSB=11, DST_LSB=0);
  - the fetch FSM state enum.
- No sub-module is needed; field extraction is inline slicing. Single module `instr_fetch`.

## Test plan
- Reset, then `start`, memory[0]=0x1800_5003 (LD, imm, src=5, dst=3), `issue_ready`=1 → cycle 3: `Opcode`=1, `srcIsImm`=1, `SrcOp`=5, `DstOp`=3, `issue_valid`=1; `pc`=1 after handshake.
- `issue_ready` held low for 4 cycles while ISSUE → fields and `issue_valid` stable for all 4 cycles; no `mem_rd`; `pc` unchanged.
- `br_taken`=1, `br_target`=0x40 during WAIT → read data discarded; next `mem_rd` with `mem_addr`=0x40; the first issued instruction is memory[0x40].
- `pc`=0xFF with PCW=8, handshake → `pc`=0x00, next fetch at address 0.
- HLT word (0x8000_0000) issued → `halted`=1 the next cycle; subsequent `start`/`br_taken` produce no `mem_rd`; `rst_n` low → `halted`=0, `pc`=RESET_PC.
- `rst_n` pulsed low during ISSUE → `issue_valid`=0 and `Opcode`=NOP asynchronously, state IDLE.
